// File: rtl/p_ctrl_if.sv
// Host-side handshake for the p_ctrl sequencer.
//   start  : job request, sampled only while the sequencer is idle
//   abort  : synchronous cancel of the running job
//   in     : 16-bit operand, captured on an accepted start
//   busy   : high whenever a job is in flight
//   done   : one-cycle completion pulse
//   cycles : accumulate plus correct cycles spent on the last job (saturating)
interface p_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] in;
  logic        busy;
  logic        done;
  logic [15:0] cycles;

  modport master (
    output start, abort, in,
    input  busy, done, cycles
  );

  modport slave (
    input  start, abort, in,
    output busy, done, cycles
  );
endinterface

// File: rtl/p_ctrl.sv
// Sequencing FSM for the 3/5/15 multiples-sum datapath.
// Latches an operand on start, then walks the datapath through clear, accumulate and
// correct phases, raising done when the datapath result holds the sum of all multiples
// of 3 or 5 strictly below the operand.
// Ports:
//   clk, rst           : rising-edge clock, asynchronous active-high reset
//   host               : start/abort/in request side, busy/done/cycles status side
//   C3, C15            : datapath counter feedback
//   op_in              : latched operand, feeds the datapath
//   RC3, RC5, RC15     : datapath counter clears
//   SC3, SC5, SC15     : datapath counter steps
//   ROut, SOut         : datapath result opcode (11 clear, 10 hold, 01 accumulate, 00 correct)
module p_ctrl #(
  parameter int unsigned CW     = 32,
  parameter int unsigned STEP3  = 3,
  parameter int unsigned STEP15 = 15
) (
  input  logic          clk,
  input  logic          rst,
  p_ctrl_if.slave       host,
  input  logic [CW-1:0] C3,
  input  logic [CW-1:0] C15,
  output logic [15:0]   op_in,
  output logic          RC3,
  output logic          RC5,
  output logic          RC15,
  output logic          SC3,
  output logic          SC5,
  output logic          SC15,
  output logic          ROut,
  output logic          SOut
);

  typedef enum logic [2:0] {StIdle, StClr, StAcc, StCorr, StFin} state_e;

  // Strobe bundle order: {RC3, RC5, RC15, SC3, SC5, SC15, ROut, SOut}
  localparam logic [7:0] StrobeHold = 8'b000_000_10;
  localparam logic [7:0] StrobeClr  = 8'b111_000_11;
  localparam logic [7:0] StrobeAcc  = 8'b000_110_01;
  localparam logic [7:0] StrobeCorr = 8'b000_001_00;

  function automatic logic [7:0] decode(input state_e s);
    logic [7:0] d;
    d = StrobeHold;
    unique case (s)
      StClr:   d = StrobeClr;
      StAcc:   d = StrobeAcc;
      StCorr:  d = StrobeCorr;
      default: d = StrobeHold;
    endcase
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] op_q;
  logic [15:0] cycles_q;
  logic        done_q;
  logic        busy_q;
  logic [7:0]  strobe_q;

  // One extra bit so counter + step never wraps before the compare.
  logic [CW:0] c3_nxt, c15_nxt, op_ext;

  assign op_ext  = (CW+1)'(op_q);
  assign c3_nxt  = {1'b0, C3} + (CW+1)'(STEP3);
  assign c15_nxt = {1'b0, C15} + (CW+1)'(STEP15);

  always_comb begin
    state_d = state_q;
    if (host.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (host.start) state_d = StClr;
        StClr:   state_d = StAcc;
        StAcc:   if (!(c3_nxt < op_ext)) state_d = StCorr;
        StCorr:  if (!(c15_nxt < op_ext)) state_d = StFin;
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with state_q
  // and never see a combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= StrobeHold;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_d == StFin);
      busy_q   <= (state_d != StIdle);
      strobe_q <= decode(state_d);
      if (state_q == StIdle && host.start && !host.abort) begin
        op_q     <= host.in;
        cycles_q <= '0;
      end else if ((state_q == StAcc || state_q == StCorr) && cycles_q != 16'hFFFF) begin
        // Counts the cycle even when abort ends it, so the partial count is kept.
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

  assign {RC3, RC5, RC15, SC3, SC5, SC15, ROut, SOut} = strobe_q;
  assign op_in       = op_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.cycles = cycles_q;

endmodule

// File: tb/tb_p_ctrl.sv
module tb_p_ctrl;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic [15:0] op;
    logic [31:0] res;
    logic [15:0] cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] c3, c5, c15, res;
  logic [15:0]   op_in;
  logic          rc3, rc5, rc15, sc3, sc5, sc15, rout, sout;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  p_ctrl_if bus ();

  p_ctrl #(.CW(CW), .STEP3(3), .STEP15(15)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .C3   (c3),
    .C15  (c15),
    .op_in(op_in),
    .RC3  (rc3),
    .RC5  (rc5),
    .RC15 (rc15),
    .SC3  (sc3),
    .SC5  (sc5),
    .SC15 (sc15),
    .ROut (rout),
    .SOut (sout)
  );

  always #5 clk = ~clk;

  // Behavioural multiples-sum datapath driven by the sequencer strobes.
  always @(posedge clk) begin
    if (rc3) c3 <= '0; else if (sc3) c3 <= c3 + 32'd3;
    if (rc5) c5 <= '0; else if (sc5) c5 <= c5 + 32'd5;
    if (rc15) c15 <= '0; else if (sc15) c15 <= c15 + 32'd15;
    case ({rout, sout})
      2'b11:   res <= '0;
      2'b01:   res <= res + c3 + (((c5 + 32'd5) < {16'd0, op_in}) ? (c5 + 32'd5) : 32'd0);
      2'b00:   res <= res - c15;
      default: res <= res;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected job.
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_done) check("done_one_cycle", {63'd0, bus.done}, 64'd0);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending job");
        end else begin
          e = sb_q.pop_front();
          check("result", {32'd0, res}, {32'd0, e.res});
          check("cycles", {48'd0, bus.cycles}, {48'd0, e.cyc});
          check("op_in_at_done", {48'd0, op_in}, {48'd0, e.op});
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle(output int nb);
    nb = 0;
    while (bus.busy && nb < 5000) begin
      nb++;
      @(negedge clk);
    end
    if (bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=1 expected idle within 5000 cycles");
    end
  endtask

  task automatic run_job(input logic [15:0] v, input logic [31:0] r, input logic [15:0] c,
                         output int nb);
    exp_t e;
    e.op  = v;
    e.res = r;
    e.cyc = c;
    sb_q.push_back(e);
    bus.in    = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(nb);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   nb;
    exp_t e;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.in    = 16'd0;
    #1 rst = 1'b1;
    #2;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_cycles", {48'd0, bus.cycles}, 64'd0);
    check("rst_op_in", {48'd0, op_in}, 64'd0);
    check("rst_strobes", {56'd0, rc3, rc5, rc15, sc3, sc5, sc15, rout, sout}, 64'h02);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic job, also confirms busy spans CLR + 4 ACC + 1 CORR + FIN.
    run_job(16'd10, 32'd23, 16'd5, nb);
    check("busy_len_10", nb, 64'd7);
    run_job(16'd16, 32'd60, 16'd8, nb);
    check("busy_len_16", nb, 64'd10);
    run_job(16'd0, 32'd0, 16'd2, nb);
    check("busy_len_0", nb, 64'd4);
    run_job(16'd3, 32'd0, 16'd2, nb);
    run_job(16'd4, 32'd3, 16'd3, nb);

    // Start and operand changes mid-job are ignored.
    e.op = 16'd16; e.res = 32'd60; e.cyc = 16'd8;
    sb_q.push_back(e);
    bus.in    = 16'd16;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.in    = 16'd5;
    bus.start = 1'b1;
    @(negedge clk);
    check("op_in_stable", {48'd0, op_in}, 64'd16);
    bus.start = 1'b0;
    bus.in    = 16'd77;
    wait_idle(nb);
    @(negedge clk);
    check("no_restart", {63'd0, bus.busy}, 64'd0);

    // Abort in the third ACC cycle.
    bus.in    = 16'd10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_cycles", {48'd0, bus.cycles}, 64'd3);

    // start with abort in IDLE: nothing happens, operand not latched.
    bus.in    = 16'd99;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", {63'd0, bus.busy}, 64'd0);
    check("start_abort_op", {48'd0, op_in}, 64'd10);
    run_job(16'd10, 32'd23, 16'd5, nb);

    // Asynchronous reset in the middle of CORR.
    bus.in    = 16'd1000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (340) @(negedge clk);
    check("in_corr", {63'd0, sc15}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_done", {63'd0, bus.done}, 64'd0);
    check("arst_op_in", {48'd0, op_in}, 64'd0);
    check("arst_strobes", {56'd0, rc3, rc5, rc15, sc3, sc5, sc15, rout, sout}, 64'h02);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(16'd1000, 32'd233168, 16'd401, nb);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
